fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, PC and memory address width SHALL be provided.
REQ-002 Parameter INSTR_WIDTH, default 32, instruction word width SHALL be provided.
REQ-003 Parameter DEPTH, default 2, max in-flight plus buffered fetches SHALL be provided.
REQ-004 Ports SHALL be (name direction width meaning):
- clk  in  1  sole clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- pc_reg  in  ADDR_WIDTH  current PC from PC register stage.
- pc_stall  out  1  hold PC register; high unless a request is accepted this cycle.
- flush  in  1  redirect; discard all fetched and in-flight instructions.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  fetch address (= pc_reg).
- imem_rsp_valid  in  1  response valid; in order, no backpressure.
- imem_rsp_data  in  INSTR_WIDTH  fetched instruction.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts.
- id_pc  out  ADDR_WIDTH  PC of presented instruction.
- id_instr  out  INSTR_WIDTH  presented instruction.

Function
REQ-005 Request SHALL be issued (imem_req_valid=1, addr=pc_reg) only in state RUN, flush low, and slots_used < DEPTH.
REQ-006 Request accepted = imem_req_valid & imem_req_ready; on accept, a queue slot SHALL be allocated at tail holding pc_reg, marked unfilled.
REQ-007 pc_stall SHALL equal NOT(accept), combinationally, same cycle.
REQ-008 In RUN, imem_rsp_valid SHALL fill the oldest unfilled slot with imem_rsp_data.
REQ-009 id_valid SHALL be high iff head slot is allocated and filled; id_pc/id_instr from head; pop on id_valid & id_ready.
REQ-010 Minimum latency: request accept at cycle N, response at N+1 -> id_valid at N+2.
REQ-011 Allocate, fill and pop in one cycle SHALL all take effect; full queue with pop SHALL still block issue that cycle (slots_used evaluated from registered state).
REQ-012 Pointers SHALL wrap modulo DEPTH; slots_used SHALL never exceed DEPTH nor underflow.
REQ-013 FSM states: RUN, DRAIN.
REQ-014 On flush: all slots cleared next cycle; drop_cnt <= outstanding minus (imem_rsp_valid ? 1 : 0); next state DRAIN if that value > 0, else RUN.
REQ-015 In DRAIN: no requests; each imem_rsp_valid discarded and decrements drop_cnt; return to RUN in the cycle after drop_cnt reaches 0.
REQ-016 Flush in DRAIN SHALL recompute drop_cnt with the same rule, remaining in or leaving DRAIN accordingly.
REQ-017 Flush coincident with id handshake: decode's transfer counts; the queue still clears.
REQ-018 imem_rsp_valid with zero outstanding SHALL be ignored (no state change).

Reset
REQ-019 On reset: queue empty, pointers 0, drop_cnt 0, state RUN; imem_req_valid=0, id_valid=0, pc_stall=1, id_pc/id_instr=0.
REQ-020 Reset mid-operation SHALL abandon in-flight requests without draining; responses arriving afterwards are ignored per REQ-018.

Structure
REQ-021 Package fetch_pkg SHALL hold the state enum (RUN, DRAIN) and default INSTR_WIDTH/DEPTH constants.
REQ-022 Sub-module fetch_queue SHALL implement the DEPTH-entry pc/instr/filled buffer with alloc, fill and pop ports.

Verification
REQ-023 Stream: pc 0x0,0x4,0x8 accepted back-to-back, 1-cycle responses, id_ready=1 -> id_pc 0x0,0x4,0x8 in order, first id_valid two cycles after first accept.
REQ-024 Backpressure: id_ready=0, two accepts -> third cycle imem_req_valid=0, pc_stall=1; id_ready=1 -> issue resumes next cycle.
REQ-025 Flush with 2 outstanding, no rsp that cycle -> DRAIN, drop_cnt=2; two responses discarded, id_valid stays 0, RUN after.
REQ-026 Flush coincident with rsp_valid, 2 outstanding -> drop_cnt=1; only next response discarded.
REQ-027 Reset asserted with 1 outstanding and 1 buffered -> all outputs at reset values next cycle; late response produces no id_valid.
REQ-028 imem_req_ready=0 for 3 cycles -> pc_stall=1 all 3 cycles, imem_req_addr tracks pc_reg, no slot allocated.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch unit and its queue.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam int DEF_ADDR_WIDTH  = 64;
  localparam int DEF_INSTR_WIDTH = 32;
  localparam int DEF_DEPTH       = 2;

  // Bits needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: slots are allocated at request time and filled when the
// matching response returns; only a filled head slot is presented to decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CW          = cnt_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   alloc,
  input  logic [ADDR_WIDTH-1:0]  alloc_pc,
  input  logic                   fill,
  input  logic [INSTR_WIDTH-1:0] fill_instr,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [ADDR_WIDTH-1:0]  head_pc,
  output logic [INSTR_WIDTH-1:0] head_instr,
  output logic [CW-1:0]          used,
  output logic [CW-1:0]          pending
);

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0]          head_reg, tail_reg, fill_ptr_reg;
  logic [CW-1:0]          used_reg, pending_reg;
  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0]       filled_reg;
  logic [DEPTH-1:0]       alloc_hit, fill_hit, pop_hit;
  logic                   alloc_en, fill_en, pop_en;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Responses with nothing outstanding are dropped here, never counted.
  assign alloc_en = alloc && (used_reg != CW'(DEPTH));
  assign fill_en  = fill && (pending_reg != '0);
  assign pop_en   = pop && filled_reg[head_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign alloc_hit[gi] = alloc_en && (tail_reg == PW'(gi));
      assign fill_hit[gi]  = fill_en && (fill_ptr_reg == PW'(gi));
      assign pop_hit[gi]   = pop_en && (head_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]     <= '0;
        instr_mem[i]  <= '0;
        filled_reg[i] <= 1'b0;
      end
    end else if (clear) begin
      filled_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_hit[i]) begin
          pc_mem[i]     <= alloc_pc;
          filled_reg[i] <= 1'b0;
        end
        if (fill_hit[i]) begin
          instr_mem[i]  <= fill_instr;
          filled_reg[i] <= 1'b1;
        end
        if (pop_hit[i]) begin
          filled_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      fill_ptr_reg <= '0;
      used_reg     <= '0;
      pending_reg  <= '0;
    end else begin
      if (alloc_en) tail_reg <= next_ptr(tail_reg);
      if (fill_en)  fill_ptr_reg <= next_ptr(fill_ptr_reg);
      if (pop_en)   head_reg <= next_ptr(head_reg);
      used_reg    <= used_reg + CW'(alloc_en) - CW'(pop_en);
      pending_reg <= pending_reg + CW'(alloc_en) - CW'(fill_en);
    end
  end

  assign head_valid = filled_reg[head_reg];
  assign head_pc    = pc_mem[head_reg];
  assign head_instr = instr_mem[head_reg];
  assign used       = used_reg;
  assign pending    = pending_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues PC requests to instruction memory, buffers responses
// in order for decode, and discards stale responses after a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  pc_reg,
  output logic                   pc_stall,
  input  logic                   flush,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [ADDR_WIDTH-1:0]  id_pc,
  output logic [INSTR_WIDTH-1:0] id_instr
);

  localparam int CW = cnt_width(DEPTH);

  fetch_state_t  state_reg;
  logic [CW-1:0] drop_cnt_reg, drop_next, outstanding, used, pending;
  logic          issue, accept, fill, pop, head_valid;

  // Occupancy comes from registered state, so a pop cannot free a slot for the same cycle.
  assign issue          = !reset && (state_reg == RUN) && !flush && (used < CW'(DEPTH));
  assign imem_req_valid = issue;
  assign imem_req_addr  = pc_reg;
  assign accept         = issue && imem_req_ready;
  assign pc_stall       = !accept;

  assign fill     = imem_rsp_valid && (state_reg == RUN) && !flush;
  assign id_valid = head_valid;
  assign pop      = head_valid && id_ready && !flush;

  // While draining the queue is empty and drop_cnt alone tracks in-flight requests.
  assign outstanding = (state_reg == DRAIN) ? drop_cnt_reg : pending;
  assign drop_next   = (imem_rsp_valid && (outstanding != '0)) ? outstanding - CW'(1) : outstanding;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      drop_cnt_reg <= '0;
    end else if (flush) begin
      drop_cnt_reg <= drop_next;
      state_reg    <= (drop_next != '0) ? DRAIN : RUN;
    end else if (state_reg == DRAIN) begin
      drop_cnt_reg <= drop_next;
      if (drop_next == '0) state_reg <= RUN;
    end
  end

  fetch_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH),
    .DEPTH      (DEPTH),
    .CW         (CW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .alloc     (accept),
    .alloc_pc  (pc_reg),
    .fill      (fill),
    .fill_instr(imem_rsp_data),
    .pop       (pop),
    .head_valid(head_valid),
    .head_pc   (id_pc),
    .head_instr(id_instr),
    .used      (used),
    .pending   (pending)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// queue-based reference model of the fetch/buffer/redirect rules.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic [63:0] pc_reg;
  logic        pc_stall;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;

  int checks;
  int failures;
  int mem_pending;
  int drain;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;
  ent_t q[$];

  fetch_unit #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_reg        (pc_reg),
    .pc_stall      (pc_stall),
    .flush         (flush),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_instr      (id_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int count_unfilled();
    int n = 0;
    foreach (q[i]) if (!q[i].filled) n++;
    return n;
  endfunction

  function automatic bit exp_req_valid();
    return !reset && !flush && (drain == 0) && (q.size() < DEPTH);
  endfunction

  function automatic bit exp_id_valid();
    return (q.size() > 0) && q[0].filled;
  endfunction

  // Advance model and memory view by one clock using the currently driven inputs.
  task automatic step();
    bit acc;
    bit done;
    int out;
    acc = exp_req_valid() && imem_req_ready;
    if (imem_rsp_valid && mem_pending > 0) mem_pending--;
    if (acc) mem_pending++;
    if (reset) begin
      q.delete();
      drain = 0;
    end else if (flush) begin
      out = drain + count_unfilled();
      if (imem_rsp_valid && out > 0) out--;
      q.delete();
      drain = out;
    end else if (drain > 0) begin
      if (imem_rsp_valid) drain--;
    end else begin
      if (exp_id_valid() && id_ready) void'(q.pop_front());
      done = 0;
      if (imem_rsp_valid) begin
        foreach (q[i]) begin
          if (!done && !q[i].filled) begin
            q[i].instr  = imem_rsp_data;
            q[i].filled = 1;
            done = 1;
          end
        end
      end
      if (acc) q.push_back('{pc: pc_reg, instr: 32'h0, filled: 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; flush = 0; imem_req_ready = 0; imem_rsp_valid = 0; id_ready = 0;
    step();
    reset = 0;
    mem_pending = 0;
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; imem_req_ready = 1; imem_rsp_valid = 0; id_ready = 0;
    pc_reg = 64'h100; imem_rsp_data = 32'h0;
    step();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid); end
    checks++;
    if (pc_stall !== 1'b1) begin failures++; $display("FAIL reset_pc_stall got=%0b exp=1", pc_stall); end
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
    checks++;
    if (id_pc !== 64'h0 || id_instr !== 32'h0) begin failures++; $display("FAIL reset_id_data got=%0h/%0h exp=0/0", id_pc, id_instr); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
    do_reset();
  endtask

  task automatic test_stream();
    int got;
    bit acc;
    logic [63:0] exp_pcs [3];
    exp_pcs = '{64'h0, 64'h4, 64'h8};
    do_reset();
    got = 0;
    pc_reg = 64'h0; imem_req_ready = 1; id_ready = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      imem_rsp_valid = (mem_pending > 0);
      imem_rsp_data  = $urandom;
      #1;
      if (cyc == 0) begin
        checks++;
        if (imem_req_valid !== 1'b1 || pc_stall !== 1'b0)
          begin failures++; $display("FAIL stream_first_accept got=%0b/%0b exp=1/0", imem_req_valid, pc_stall); end
      end
      if (cyc == 1) begin
        checks++;
        if (id_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid got=%0b exp=0", id_valid); end
      end
      if (id_valid === 1'b1 && got < 3) begin
        checks++;
        if (id_pc !== exp_pcs[got]) begin failures++; $display("FAIL stream_pc got=%0h exp=%0h", id_pc, exp_pcs[got]); end
        if (got == 0) begin
          checks++;
          if (cyc != 2) begin failures++; $display("FAIL stream_latency got=%0d exp=2", cyc); end
        end
        got++;
      end
      acc = exp_req_valid() && imem_req_ready;
      step();
      if (acc) pc_reg = pc_reg + 64'h4;
    end
    checks++;
    if (got != 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", got); end
    $display("test_stream done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_backpressure();
    do_reset();
    id_ready = 0; imem_req_ready = 1; imem_rsp_valid = 0; pc_reg = 64'h40;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || pc_stall !== 1'b0) begin failures++; $display("FAIL bp_accept0 got=%0b/%0b exp=1/0", imem_req_valid, pc_stall); end
    step();
    pc_reg = 64'h44; imem_rsp_valid = 1; imem_rsp_data = 32'hA0A0_0040;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || pc_stall !== 1'b0) begin failures++; $display("FAIL bp_accept1 got=%0b/%0b exp=1/0", imem_req_valid, pc_stall); end
    step();
    pc_reg = 64'h48; imem_rsp_valid = 1; imem_rsp_data = 32'hA0A0_0044;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1) begin failures++; $display("FAIL bp_full_block got=%0b/%0b exp=0/1", imem_req_valid, pc_stall); end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 64'h40) begin failures++; $display("FAIL bp_head got=%0b/%0h exp=1/40", id_valid, id_pc); end
    step();
    imem_rsp_valid = 0; id_ready = 1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_pop_cycle_block got=%0b exp=0", imem_req_valid); end
    step();
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || pc_stall !== 1'b0) begin failures++; $display("FAIL bp_resume got=%0b/%0b exp=1/0", imem_req_valid, pc_stall); end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 64'h44 || id_instr !== 32'hA0A0_0044)
      begin failures++; $display("FAIL bp_second got=%0b/%0h/%0h exp=1/44/a0a00044", id_valid, id_pc, id_instr); end
    step();
    $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_flush_drain();
    do_reset();
    id_ready = 1; imem_req_ready = 1; imem_rsp_valid = 0; pc_reg = 64'h80;
    step();
    pc_reg = 64'h84;
    step();
    flush = 1; imem_rsp_valid = 0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1) begin failures++; $display("FAIL fd_flush_cycle got=%0b/%0b exp=0/1", imem_req_valid, pc_stall); end
    step();
    flush = 0;
    for (int k = 0; k < 2; k++) begin
      imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_0000 + k;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL fd_drain%0d got=%0b/%0b exp=0/0", k, imem_req_valid, id_valid); end
      step();
    end
    imem_rsp_valid = 0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || id_valid !== 1'b0) begin failures++; $display("FAIL fd_run_after got=%0b/%0b exp=1/0", imem_req_valid, id_valid); end
    $display("test_flush_drain done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_flush_rsp();
    do_reset();
    id_ready = 1; imem_req_ready = 1; imem_rsp_valid = 0; pc_reg = 64'hC0;
    step();
    pc_reg = 64'hC4;
    step();
    flush = 1; imem_rsp_valid = 1; imem_rsp_data = 32'h1111_1111;
    step();
    flush = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h2222_2222;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL fr_drain got=%0b/%0b exp=0/0", imem_req_valid, id_valid); end
    step();
    imem_rsp_valid = 0; pc_reg = 64'h100;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL fr_resume got=%0b exp=1", imem_req_valid); end
    step();
    imem_rsp_valid = 1; imem_rsp_data = 32'h3333_3333;
    #1;
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL fr_not_yet got=%0b exp=0", id_valid); end
    step();
    imem_rsp_valid = 0; imem_req_ready = 0;
    #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 64'h100 || id_instr !== 32'h3333_3333)
      begin failures++; $display("FAIL fr_new_instr got=%0b/%0h/%0h exp=1/100/33333333", id_valid, id_pc, id_instr); end
    step();
    $display("test_flush_rsp done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    do_reset();
    id_ready = 0; imem_req_ready = 1; imem_rsp_valid = 0; pc_reg = 64'h200;
    step();
    pc_reg = 64'h204; imem_rsp_valid = 1; imem_rsp_data = 32'h5555_0200;
    step();
    imem_rsp_valid = 0;
    #1;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 64'h200) begin failures++; $display("FAIL rm_buffered got=%0b/%0h exp=1/200", id_valid, id_pc); end
    reset = 1;
    step();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1 || id_valid !== 1'b0 || id_pc !== 64'h0 || id_instr !== 32'h0)
      begin failures++; $display("FAIL rm_reset_vals got=%0b/%0b/%0b/%0h/%0h exp=0/1/0/0/0", imem_req_valid, pc_stall, id_valid, id_pc, id_instr); end
    reset = 0; imem_req_ready = 0; id_ready = 1; imem_rsp_valid = 1; imem_rsp_data = 32'h7777_0204;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || pc_stall !== 1'b1) begin failures++; $display("FAIL rm_after_reset got=%0b/%0b exp=1/1", imem_req_valid, pc_stall); end
    step();
    imem_rsp_valid = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (id_valid !== 1'b0) begin failures++; $display("FAIL rm_late_rsp%0d got=%0b exp=0", k, id_valid); end
      step();
    end
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_req_stall();
    do_reset();
    imem_req_ready = 0; id_ready = 0; imem_rsp_valid = 0;
    for (int k = 0; k < 3; k++) begin
      pc_reg = {$urandom, $urandom} & ~64'h3;
      #1;
      checks++;
      if (pc_stall !== 1'b1 || imem_req_valid !== 1'b1 || imem_req_addr !== pc_reg)
        begin failures++; $display("FAIL rs_stall%0d got=%0b/%0b/%0h exp=1/1/%0h", k, pc_stall, imem_req_valid, imem_req_addr, pc_reg); end
      step();
    end
    imem_req_ready = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (imem_req_valid !== (k < 2)) begin failures++; $display("FAIL rs_slots%0d got=%0b exp=%0b", k, imem_req_valid, (k < 2)); end
      step();
    end
    $display("test_req_stall done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    bit erv, eiv;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset          = ($urandom_range(0, 199) == 0);
      flush          = ($urandom_range(0, 24) == 0);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      id_ready       = ($urandom_range(0, 9) < 6);
      imem_rsp_valid = (mem_pending > 0) && ($urandom_range(0, 9) < 6);
      imem_rsp_data  = $urandom;
      pc_reg         = {$urandom, $urandom} & ~64'h3;
      #1;
      erv = exp_req_valid();
      eiv = exp_id_valid();
      checks++;
      if (imem_req_valid !== erv) begin failures++; $display("FAIL rnd_req_valid cyc=%0d got=%0b exp=%0b", cyc, imem_req_valid, erv); end
      checks++;
      if (pc_stall !== !(erv && imem_req_ready)) begin failures++; $display("FAIL rnd_pc_stall cyc=%0d got=%0b exp=%0b", cyc, pc_stall, !(erv && imem_req_ready)); end
      if (erv) begin
        checks++;
        if (imem_req_addr !== pc_reg) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%0h exp=%0h", cyc, imem_req_addr, pc_reg); end
      end
      checks++;
      if (id_valid !== eiv) begin failures++; $display("FAIL rnd_id_valid cyc=%0d got=%0b exp=%0b", cyc, id_valid, eiv); end
      if (eiv) begin
        checks++;
        if (id_pc !== q[0].pc || id_instr !== q[0].instr)
          begin failures++; $display("FAIL rnd_id_data cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, id_pc, id_instr, q[0].pc, q[0].instr); end
      end
      step();
    end
    reset = 0; flush = 0;
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks = 0; failures = 0; mem_pending = 0; drain = 0;
    reset = 1; flush = 0; imem_req_ready = 0; imem_rsp_valid = 0; id_ready = 0;
    pc_reg = 64'h0; imem_rsp_data = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_drain();
    test_flush_rsp();
    test_reset_mid();
    test_req_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
